// File: rtl/fifo_wr_arbiter_pkg.sv
// Shared types and helpers for the round-robin FIFO write-port arbiter.
// The state encoding is fixed so that IDLE=0 and GRANT=1.
package fifo_wr_arbiter_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_e;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Combinational round-robin search: the first requesting index found when
// searching upward from last+1 and wrapping modulo N.
module rr_pick
    import fifo_wr_arbiter_pkg::*;
#(
    parameter int N  = 4,
    parameter int IW = clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] last,
    output logic [IW-1:0] idx,
    output logic          any
);

    logic [IW-1:0] k;

    // Walk the offsets from farthest to nearest so the nearest hit is written last.
    always_comb begin
        idx = '0;
        k   = '0;
        any = |req;
        for (int off = N; off >= 1; off--) begin
            k = IW'((int'(last) + off) % N);
            if (req[k]) idx = k;
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Shares one FIFO write port among N_REQ requesters, granting bursts of up to
// BURST words in round-robin order; data and write enable are zero-latency.
module fifo_wr_arbiter
    import fifo_wr_arbiter_pkg::*;
#(
    parameter int N_REQ  = 4,
    parameter int DATA_W = 8,
    parameter int BURST  = 4
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic [N_REQ-1:0]        req_i,
    input  logic [N_REQ*DATA_W-1:0] data_i,
    output logic [N_REQ-1:0]        ack_o,
    input  logic                    full_i,
    output logic                    we_o,
    output logic [DATA_W-1:0]       data_o,
    output logic [N_REQ-1:0]        gnt_o,
    output logic                    busy_o
);

    localparam int            IW       = clog2(N_REQ);
    localparam int            CW       = clog2(BURST + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(BURST - 1);

    generate
        if (BURST < 1 || N_REQ < 2 || N_REQ > 8) begin : g_bad_params
            $error("fifo_wr_arbiter: need BURST >= 1 and 2 <= N_REQ <= 8");
        end
    endgenerate

    state_e            state_q, state_d;
    logic [IW-1:0]     owner_q, owner_d;
    logic [IW-1:0]     last_q, last_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [IW-1:0]     pick_idx;
    logic              pick_any;
    logic              own_req;
    logic              xfer;
    logic [N_REQ-1:0]  own_oh;

    rr_pick #(.N(N_REQ), .IW(IW)) u_pick (
        .req  (req_i),
        .last (last_q),
        .idx  (pick_idx),
        .any  (pick_any)
    );

    // Outputs are masked by reset so an in-flight burst cannot write in the reset cycle.
    assign own_oh  = {{(N_REQ-1){1'b0}}, 1'b1} << owner_q;
    assign own_req = req_i[owner_q];
    assign busy_o  = (state_q == GRANT) && !rst_i;
    assign gnt_o   = busy_o ? own_oh : '0;
    assign ack_o   = (busy_o && !full_i) ? own_oh : '0;
    assign xfer    = busy_o && !full_i && own_req;
    assign we_o    = xfer;
    assign data_o  = data_i[int'(owner_q)*DATA_W +: DATA_W];

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (pick_any) begin
                    owner_d = pick_idx;
                    cnt_d   = '0;
                    state_d = GRANT;
                end
            end
            GRANT: begin
                if (!own_req) begin
                    state_d = IDLE;
                    last_d  = owner_q;
                end else if (xfer) begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CNT_LAST) begin
                        state_d = IDLE;
                        last_d  = owner_q;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            owner_q <= '0;
            last_q  <= IW'(N_REQ - 1);
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Scoreboard bench for fifo_wr_arbiter: per-requester word sources, expected
// write order queued at stimulus time, popped on every observed FIFO write.
module tb_fifo_wr_arbiter;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [3:0]  req_i;
    logic [31:0] data_i;
    logic [3:0]  ack_o;
    logic        full_i;
    logic        we_o;
    logic [7:0]  data_o;
    logic [3:0]  gnt_o;
    logic        busy_o;

    fifo_wr_arbiter #(.N_REQ(4), .DATA_W(8), .BURST(4)) dut (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .req_i  (req_i),
        .data_i (data_i),
        .ack_o  (ack_o),
        .full_i (full_i),
        .we_o   (we_o),
        .data_o (data_o),
        .gnt_o  (gnt_o),
        .busy_o (busy_o)
    );

    always #5 clk_i = ~clk_i;

    int         n_cmp = 0;
    int         n_err = 0;
    int         cyc   = 0;
    logic [7:0] src_mem [4][16];
    int         src_rd [4];
    int         src_wr [4];
    logic [7:0] exp_q [$];
    logic [3:0] gq [$];
    int         gc [$];
    logic [3:0] prev_gnt;
    logic [3:0] xfer_s;
    logic       full_force;
    logic       fifo_en;
    int         fcnt;
    int         ftot;
    logic [9:0] we_log;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic drive();
        for (int k = 0; k < 4; k++) begin
            req_i[k] = src_rd[k] < src_wr[k];
            data_i[k*8 +: 8] = req_i[k] ? src_mem[k][src_rd[k]] : 8'h00;
        end
        full_i = fifo_en ? (fcnt >= 32) : full_force;
    endtask

    task automatic push_src(input int k, input logic [7:0] d);
        src_mem[k][src_wr[k]] = d;
        src_wr[k]++;
    endtask

    // Mid-cycle observation: scoreboard pop, FIFO model, grant-start log.
    task automatic sample();
        @(negedge clk_i);
        cyc++;
        xfer_s = req_i & ack_o;
        chk("we_vs_handshake", {31'd0, we_o}, {31'd0, |xfer_s});
        if (we_o) begin
            chk("write_expected", {31'd0, exp_q.size() != 0}, 32'd1);
            if (exp_q.size() != 0) chk("wdata", {24'd0, data_o}, {24'd0, exp_q.pop_front()});
            if (fifo_en) begin
                chk("we_while_full", {31'd0, full_i}, 32'd0);
                fcnt++;
                ftot++;
            end
        end
        if (gnt_o != 4'd0 && prev_gnt == 4'd0) begin
            gq.push_back(gnt_o);
            gc.push_back(cyc);
        end
        prev_gnt = gnt_o;
    endtask

    task automatic advance();
        @(posedge clk_i);
        #1;
        for (int k = 0; k < 4; k++) if (xfer_s[k]) src_rd[k]++;
        drive();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin
            sample();
            advance();
        end
    endtask

    task automatic do_reset();
        rst_i      = 1'b1;
        full_force = 1'b0;
        fifo_en    = 1'b0;
        fcnt       = 0;
        ftot       = 0;
        for (int k = 0; k < 4; k++) begin
            src_rd[k] = 0;
            src_wr[k] = 0;
        end
        gq.delete();
        gc.delete();
        drive();
        for (int i = 0; i < 2; i++) begin
            sample();
            chk("rst_we",   {31'd0, we_o},   32'd0);
            chk("rst_ack",  {28'd0, ack_o},  32'd0);
            chk("rst_gnt",  {28'd0, gnt_o},  32'd0);
            chk("rst_busy", {31'd0, busy_o}, 32'd0);
            advance();
        end
        rst_i = 1'b0;
        drive();
    endtask

    initial begin
        rst_i    = 1'b1;
        req_i    = '0;
        data_i   = '0;
        full_i   = 1'b0;
        prev_gnt = '0;
        xfer_s   = '0;
        we_log   = '0;

        // Single requester, 6 words: burst of 4, one IDLE cycle, then 2.
        do_reset();
        for (int i = 0; i < 6; i++) begin
            push_src(0, 8'hA0 + 8'(i));
            exp_q.push_back(8'hA0 + 8'(i));
        end
        drive();
        for (int i = 0; i < 10; i++) begin
            sample();
            we_log = {we_log[8:0], we_o};
            if (i == 0) begin
                chk("s1_gnt_c1",  {28'd0, gnt_o},  32'd0);
                chk("s1_busy_c1", {31'd0, busy_o}, 32'd0);
            end
            if (i == 1) chk("s1_gnt_c2", {28'd0, gnt_o}, 32'h1);
            advance();
        end
        chk("s1_we_pattern", {22'd0, we_log}, {22'd0, 10'b0111101100});
        chk("s1_sb_empty", exp_q.size(), 32'd0);

        // All four requesting: rotation 0,1,2,3,0,... with a 5-cycle period.
        do_reset();
        for (int k = 0; k < 4; k++)
            for (int i = 0; i < 8; i++) push_src(k, 8'(k*16 + i));
        for (int r = 0; r < 2; r++)
            for (int k = 0; k < 4; k++)
                for (int j = 0; j < 4; j++) exp_q.push_back(8'(k*16 + r*4 + j));
        drive();
        run(46);
        chk("s2_grants", gq.size(), 32'd8);
        for (int i = 0; i < gq.size() && i < 8; i++) begin
            chk("s2_owner", {28'd0, gq[i]}, 32'd1 << (i % 4));
            if (i > 0) chk("s2_period", gc[i] - gc[i-1], 32'd5);
        end
        chk("s2_sb_empty", exp_q.size(), 32'd0);

        // Owner 2 stalled by full for 3 cycles at cnt=2, then finishes.
        do_reset();
        for (int i = 0; i < 4; i++) begin
            push_src(2, 8'h20 + 8'(i));
            exp_q.push_back(8'h20 + 8'(i));
        end
        drive();
        run(3);
        full_force = 1'b1;
        drive();
        for (int i = 0; i < 3; i++) begin
            sample();
            chk("s3_we_full",  {31'd0, we_o},  32'd0);
            chk("s3_ack_full", {28'd0, ack_o}, 32'd0);
            chk("s3_gnt_full", {28'd0, gnt_o}, 32'h4);
            advance();
        end
        full_force = 1'b0;
        drive();
        sample();
        chk("s3_we_resume",  {31'd0, we_o},  32'd1);
        chk("s3_gnt_resume", {28'd0, gnt_o}, 32'h4);
        advance();
        run(1);
        sample();
        chk("s3_idle_after", {28'd0, gnt_o}, 32'd0);
        advance();
        chk("s3_sb_empty", exp_q.size(), 32'd0);

        // Owner 1 withdraws after 2 words; 0 and 3 arrive mid-grant, 3 is next.
        do_reset();
        push_src(1, 8'h10);
        push_src(1, 8'h11);
        exp_q.push_back(8'h10);
        exp_q.push_back(8'h11);
        drive();
        run(2);
        push_src(0, 8'h00);
        push_src(3, 8'h30);
        exp_q.push_back(8'h30);
        exp_q.push_back(8'h00);
        drive();
        sample();
        chk("s4_ack_owner_only", {28'd0, ack_o}, 32'h2);
        advance();
        sample();
        chk("s4_no_extra_we", {31'd0, we_o},  32'd0);
        chk("s4_gnt_withdraw", {28'd0, gnt_o}, 32'h2);
        advance();
        sample();
        chk("s4_idle_gap", {28'd0, gnt_o}, 32'd0);
        advance();
        sample();
        chk("s4_next_owner", {28'd0, gnt_o}, 32'h8);
        advance();
        run(5);
        chk("s4_sb_empty", exp_q.size(), 32'd0);

        // Reset lands mid-burst of owner 3; afterwards requester 1 wins first.
        do_reset();
        for (int i = 0; i < 4; i++) push_src(3, 8'h30 + 8'(i));
        exp_q.push_back(8'h30);
        drive();
        run(2);
        rst_i = 1'b1;
        drive();
        sample();
        chk("s5_we_in_rst",  {31'd0, we_o},   32'd0);
        chk("s5_ack_in_rst", {28'd0, ack_o},  32'd0);
        chk("s5_gnt_in_rst", {28'd0, gnt_o},  32'd0);
        advance();
        do_reset();
        push_src(1, 8'h10);
        push_src(3, 8'h3A);
        exp_q.push_back(8'h10);
        exp_q.push_back(8'h3A);
        drive();
        sample();
        chk("s5_gnt_c1", {28'd0, gnt_o}, 32'd0);
        advance();
        sample();
        chk("s5_first_owner", {28'd0, gnt_o}, 32'h2);
        advance();
        run(6);
        chk("s5_sb_empty", exp_q.size(), 32'd0);

        // Depth-32 FIFO with stalled reader: exactly 32 accepted, rest after drain.
        do_reset();
        fifo_en = 1'b1;
        for (int k = 0; k < 4; k++)
            for (int i = 0; i < 10; i++) push_src(k, 8'(k*16 + i));
        for (int r = 0; r < 2; r++)
            for (int k = 0; k < 4; k++)
                for (int j = 0; j < 4; j++) exp_q.push_back(8'(k*16 + r*4 + j));
        for (int k = 0; k < 4; k++)
            for (int j = 8; j < 10; j++) exp_q.push_back(8'(k*16 + j));
        drive();
        run(60);
        chk("s6_accepted_full", fcnt, 32'd32);
        fcnt = 0;
        drive();
        run(30);
        chk("s6_total", ftot, 32'd40);
        chk("s6_sb_empty", exp_q.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
